// File: rtl/routing_ctrl_pkg.sv
// Purpose: shared constants, FSM state type and status-word layout for the crosspoint switch loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package routing_ctrl_pkg;

    // Command word fields, as written by the routing controller PIO.
    localparam int TOGGLE_BIT    = 31;
    localparam int LATCH_REQ_BIT = 30;
    localparam int CLR_OVR_BIT   = 29;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LATCH
    } state_e;

    // Status word layout for the readback PIO input port.
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_OVR_BIT  = 1;
    localparam int STAT_CNT_LSB  = 8;

    function automatic logic [31:0] pack_status(input logic       busy,
                                                input logic       ovr,
                                                input logic [7:0] cnt);
        logic [31:0] w;
        w                     = '0;
        w[STAT_BUSY_BIT]      = busy;
        w[STAT_OVR_BIT]       = ovr;
        w[STAT_CNT_LSB +: 8]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/routing_switch_loader_if.sv
// Purpose: bundles the PIO command word, the serial switch pins and the status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; commands are toggle-triggered and dropped (overrun) while busy.
// Ports: cmd_word (PIO -> loader); sw_sclk/sw_sdata/sw_cs_n/sw_latch (loader -> switch);
//        busy/cmd_count/overrun (loader -> PIO readback).
interface routing_switch_loader_if;
    logic [31:0] cmd_word;
    logic        sw_sclk;
    logic        sw_sdata;
    logic        sw_cs_n;
    logic        sw_latch;
    logic        busy;
    logic [7:0]  cmd_count;
    logic        overrun;

    modport master (
        output cmd_word,
        input  sw_sclk, sw_sdata, sw_cs_n, sw_latch, busy, cmd_count, overrun
    );

    modport slave (
        input  cmd_word,
        output sw_sclk, sw_sdata, sw_cs_n, sw_latch, busy, cmd_count, overrun
    );
endinterface

// File: rtl/routing_tick_gen.sv
// Purpose: half-period tick generator; tick_o pulses every DIV clk cycles.
// Latency: first tick DIV cycles after restart_i; restart_i is synchronous.
// Backpressure: none (free-running).
// Ports: clk, rst (async active-high), restart_i (sync counter clear), tick_o.
module routing_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/routing_switch_loader.sv
// Purpose: on each toggle of cmd_word[31], shifts DATA_BITS of route data MSB-first into the crosspoint switch.
// Latency: frame busy for CLK_DIV*(2*DATA_BITS+2) cycles, plus LATCH_CYCLES when a latch is requested.
// Backpressure: none; a toggle while busy is dropped and sets the sticky overrun flag.
// Ports: clk, reset (async active-high), bus (slave modport: command in, switch pins and status out).
module routing_switch_loader
    import routing_ctrl_pkg::*;
#(
    parameter int DATA_BITS    = 24,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    routing_switch_loader_if.slave  bus
);
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    state_e                 state_q, state_d;
    logic                   prev_q, prev_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   latch_req_q, latch_req_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]          lcnt_q, lcnt_d;
    logic                   sclk_q, sclk_d;
    logic                   sdata_q, sdata_d;
    logic                   cs_n_q, cs_n_d;
    logic                   latch_q, latch_d;
    logic [7:0]             count_q, count_d;
    logic                   ovr_q, ovr_d;

    logic                   restart;
    logic                   tick;
    logic                   toggle_chg;
    logic [DATA_BITS-1:0]   data_shl;

    routing_tick_gen #(.DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst       (reset),
        .restart_i (restart),
        .tick_o    (tick)
    );

    assign toggle_chg = (bus.cmd_word[TOGGLE_BIT] != prev_q);
    assign data_shl   = data_q << 1;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        data_d      = data_q;
        latch_req_d = latch_req_q;
        bit_cnt_d   = bit_cnt_q;
        lcnt_d      = lcnt_q;
        sclk_d      = sclk_q;
        sdata_d     = sdata_q;
        cs_n_d      = cs_n_q;
        latch_d     = latch_q;
        count_d     = count_q;
        ovr_d       = ovr_q;
        restart     = 1'b0;

        // Every toggle edge is consumed; outside IDLE it is dropped as an overrun.
        if (toggle_chg) begin
            prev_d = bus.cmd_word[TOGGLE_BIT];
            if (state_q != IDLE) begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (toggle_chg) begin
                    data_d      = bus.cmd_word[DATA_BITS-1:0];
                    latch_req_d = bus.cmd_word[LATCH_REQ_BIT];
                    if (bus.cmd_word[CLR_OVR_BIT]) begin
                        ovr_d = 1'b0;
                    end
                    sdata_d   = bus.cmd_word[DATA_BITS-1];
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    bit_cnt_d = '0;
                    restart   = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        // Falling edge: present the next bit for the following rising edge.
                        sclk_d  = 1'b0;
                        data_d  = data_shl;
                        sdata_d = data_shl[DATA_BITS-1];
                    end else if (bit_cnt_q == 5'(DATA_BITS - 1)) begin
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        sclk_d    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d = 1'b1;
                    if (latch_req_q) begin
                        latch_d = 1'b1;
                        lcnt_d  = '0;
                        state_d = LATCH;
                    end else begin
                        sdata_d = 1'b0;
                        count_d = count_q + 8'd1;
                        state_d = IDLE;
                    end
                end
            end
            LATCH: begin
                if (lcnt_q == LW'(LATCH_CYCLES - 1)) begin
                    latch_d = 1'b0;
                    sdata_d = 1'b0;
                    count_d = count_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_q      <= 1'b0;
            data_q      <= '0;
            latch_req_q <= 1'b0;
            bit_cnt_q   <= '0;
            lcnt_q      <= '0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            latch_q     <= 1'b0;
            count_q     <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            data_q      <= data_d;
            latch_req_q <= latch_req_d;
            bit_cnt_q   <= bit_cnt_d;
            lcnt_q      <= lcnt_d;
            sclk_q      <= sclk_d;
            sdata_q     <= sdata_d;
            cs_n_q      <= cs_n_d;
            latch_q     <= latch_d;
            count_q     <= count_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.sw_sclk   = sclk_q;
    assign bus.sw_sdata  = sdata_q;
    assign bus.sw_cs_n   = cs_n_q;
    assign bus.sw_latch  = latch_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.cmd_count = count_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: doc/routing_switch_loader.md
Name: routing_switch_loader

Overview:
- Sits directly downstream of the routing-controller 32-bit PIO output register; consumes its out_port word as a command.
- Each toggle of the command word's bit 31 launches one serial load of a route word into the external crosspoint switch.
- Load is MSB-first, with optional latch pulse.
- Provides busy/count/overrun status for readback through a PIO input port.

Parameters:
- DATA_BITS, 24, route-word bits shifted per command (taken from cmd_word[DATA_BITS-1:0]); legal 1..28.
- CLK_DIV, 4, clk cycles per sclk half-period; legal >= 1.
- LATCH_CYCLES, 2, width of sw_latch pulse in clk cycles; legal >= 1.

Ports:
- clk  in  1  system clock, same domain as the PIO.
- reset  in  1  asynchronous, active-high reset.
- cmd_word  in  32  command word from the PIO out_port:
  - [31] toggle
  - [30] latch_req
  - [29] clr_ovr
  - [DATA_BITS-1:0] route data
- sw_sclk  out  1  serial clock to the switch; data sampled by the switch on the rising edge.
- sw_sdata  out  1  serial data, MSB first.
- sw_cs_n  out  1  active-low frame select.
- sw_latch  out  1  active-high update strobe.
- busy  out  1  high while a command is in progress.
- cmd_count  out  8  count of completed commands, wraps 255->0.
- overrun  out  1  sticky; set when a toggle arrives while busy.

Behaviour:
- Reset (async, immediate, also mid-frame):
  - sw_sclk=0, sw_sdata=0, sw_cs_n=1, sw_latch=0, busy=0, cmd_count=0, overrun=0, prev_toggle=0, state=IDLE.
  - Any in-flight frame is abandoned.
- Accept:
  - In IDLE, when cmd_word[31] != prev_toggle, the command is accepted on that edge.
  - Capture data, latch_req and clr_ovr; set prev_toggle=cmd_word[31].
  - busy=1, sw_cs_n=0 and sw_sdata=data[DATA_BITS-1] from that edge.
  - If clr_ovr=1, overrun clears on the same edge. If overrun would also set on that edge, set wins; this cannot occur in IDLE.
- States:
  - IDLE -> SETUP on accept.
  - SETUP: CLK_DIV cycles, sclk low.
  - SHIFT: per bit, CLK_DIV cycles sclk high, then CLK_DIV cycles sclk low. sw_sdata updates to the next bit on the falling edge. After the last bit's low half, go to HOLD.
  - HOLD: CLK_DIV cycles, sclk low. sw_cs_n=1 at HOLD exit.
  - HOLD exit -> LATCH if latch_req=1, else -> IDLE.
  - LATCH: sw_latch=1 for exactly LATCH_CYCLES cycles, then -> IDLE.
  - Return to IDLE: busy=0, cmd_count+=1 (mod 256), sw_sdata=0.
- Timing:
  - busy duration = CLK_DIV + 2*CLK_DIV*DATA_BITS + CLK_DIV + (latch_req ? LATCH_CYCLES : 0).
  - Defaults: 200 cycles without latch, 202 with latch.
  - sw_latch never overlaps sw_cs_n=0.
- Overrun:
  - A toggle change while busy sets overrun, updates prev_toggle and drops the command; the frame in progress is unaffected.
  - Multiple changes while busy are each dropped; overrun stays 1.
  - No command queuing.
- The data field is sampled only at accept; cmd_word changes mid-frame (other than bit 31) are ignored.
- Back-to-back: a toggle change seen in the same cycle busy drops is accepted, because state is IDLE. The minimum gap between frames is one cycle.

Decomposition:
- Package routing_ctrl_pkg holds:
  - bit positions TOGGLE_BIT=31, LATCH_REQ_BIT=30, CLR_OVR_BIT=29;
  - state enum IDLE/SETUP/SHIFT/HOLD/LATCH;
  - status-word bit layout for the readback PIO.
- One sub-module, routing_tick_gen: a CLK_DIV half-period tick counter with sync restart and async reset, instantiated once.
- Bit counter, shift register and FSM stay in the top.

Test Plan:
- Reset then cmd_word 0x80ABCDEF with defaults:
  - busy high for 200 cycles;
  - switch-model shift register captures 0xABCDEF over 24 rising sclk edges;
  - no sw_latch pulse; cmd_count=1.
- cmd_word 0x40123456 after the prior toggle=1 (toggle->0, latch_req=1):
  - 24 bits 0x123456 captured;
  - sw_latch high exactly 2 cycles after sw_cs_n rises;
  - busy 202 cycles; cmd_count=2.
- Toggle twice during a frame:
  - frame completes intact; both extra commands dropped; overrun=1; cmd_count +1 only.
  - Next accepted command with bit 29 set clears overrun at accept.
- Assert reset at cycle 50 of a frame:
  - all outputs return to reset values immediately;
  - after release, a new toggle produces a full, correct frame.
- Issue 256 commands back-to-back, each toggle applied the cycle busy falls:
  - every frame correct; inter-frame gap 1 cycle; cmd_count wraps to 0.
- Parameter sweep CLK_DIV=1, DATA_BITS=1, data 0x1:
  - busy = 1+2+1 = 4 cycles; one sclk pulse; captured bit = 1.
